// File: rtl/media_loader_if.sv
// ---------------------------------------------------------------------------
// media_loader_if
//   Groups the hps_io ioctl download stream with the memory write port that
//   media_loader drives from it.
//
//   ioctl_download  hps -> loader  download in progress
//   ioctl_index     hps -> loader  file type index
//   ioctl_wr        hps -> loader  byte strobe
//   ioctl_addr      hps -> loader  byte offset in file
//   ioctl_dout      hps -> loader  byte data
//   ioctl_file_ext  hps -> loader  file extension, last char in [7:0]
//   dl_addr         loader -> mem  memory write address
//   dl_data         loader -> mem  memory write data
//   dl_wr           loader -> mem  one-cycle write strobe
//
//   master: the download source (hps_io or a bench)
//   slave : media_loader
// ---------------------------------------------------------------------------
interface media_loader_if #(
    parameter int ADDR_W = 16
) ();
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [31:0]       ioctl_file_ext;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wr;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_file_ext,
        input  dl_addr, dl_data, dl_wr
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_file_ext,
        output dl_addr, dl_data, dl_wr
    );
endinterface

// File: rtl/media_loader.sv
// ---------------------------------------------------------------------------
// media_loader
//   PRG / CRT / headerless-cart download engine. Parses the 2-byte load
//   address header (PRG, CRT) or derives the base from the file extension
//   (RAW), streams bytes to memory with a per-mode upper limit, records which
//   cart blocks were touched, and after a PRG load writes the end address
//   into a list of BASIC pointer pairs.
//
//   clk_sys     in   system clock
//   reset_n     in   synchronous active-low reset
//   bus         slave modport of media_loader_if (ioctl stream + dl_* port)
//   cart_blk    out  sticky block-occupied flags, one per top-address block
//   cart_reset  out  high while a CRT/RAW download is in progress
//   end_addr    out  address following the last accepted byte
//   busy        out  high whenever the engine is not idle
//   overflow    out  sticky: a byte was dropped at the limit
//
//   Assumes ADDR_W >= 16: the header and the pointer fixups carry 16 bits.
// ---------------------------------------------------------------------------
module media_loader #(
    parameter int                       ADDR_W     = 16,
    parameter int                       BLK_BITS   = 3,
    parameter int                       PRG_IDX    = 1,
    parameter int                       CRT_IDX    = 2,
    parameter int                       RAW_IDX    = 3,
    parameter logic [ADDR_W-1:0]        PRG_LIMIT  = 16'hA000,
    parameter logic [ADDR_W-1:0]        CART_LIMIT = 16'hC000,
    parameter logic [ADDR_W-1:0]        RAW_DEF    = 16'hA000,
    parameter int                       NPTR       = 4,
    parameter logic [NPTR*ADDR_W-1:0]   PTR_LIST   = {16'h00AE, 16'h0031, 16'h002F, 16'h002D},
    parameter int                       FIX_GAP    = 2
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    media_loader_if.slave             bus,
    output logic [2**BLK_BITS-1:0]    cart_blk,
    output logic                      cart_reset,
    output logic [ADDR_W-1:0]         end_addr,
    output logic                      busy,
    output logic                      overflow
);

    localparam int NFIX  = 2 * NPTR;
    localparam int FIX_W = (NFIX > 1) ? $clog2(NFIX) : 1;
    localparam int GAP_W = (FIX_GAP > 1) ? $clog2(FIX_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_STREAM, S_FIX, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_OTHER, M_PRG, M_CRT, M_RAW
    } mode_t;

    state_t             state, state_nxt;
    mode_t              mode, new_mode;
    logic               dl_q;
    logic               rise, fall, rise_go;
    logic [ADDR_W-1:0]  addr, addr_nxt, limit;
    logic               hdr_lo_ld, hdr_hi_ld, byte_ok, byte_drop, fix_go;
    logic [FIX_W-1:0]   fix_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [ADDR_W-1:0]  fix_addr;
    logic [7:0]         fix_data;

    // Only the last extension character selects the RAW base.
    logic unused_ext;
    assign unused_ext = ^bus.ioctl_file_ext[31:8];

    // Base address of a headerless cart image from its extension's last char:
    // '2'..'9' -> 2000..9000, 'A'/'B' -> A000/B000, anything else -> RAW_DEF.
    function automatic logic [ADDR_W-1:0] raw_base(input logic [7:0] c);
        logic [ADDR_W-1:0] b;
        b = RAW_DEF;
        if (c >= 8'h32 && c <= 8'h39) begin
            b = '0;
            b[ADDR_W-1 -: 4] = c[3:0];
        end else if (c == 8'h41 || c == 8'h42) begin
            b = '0;
            b[ADDR_W-1 -: 4] = c[3:0] + 4'd9;
        end
        return b;
    endfunction

    assign rise    = bus.ioctl_download & ~dl_q;
    assign fall    = ~bus.ioctl_download & dl_q;
    assign rise_go = rise && (new_mode != M_OTHER);
    assign busy    = (state != S_IDLE);

    always_comb begin
        if (bus.ioctl_index == 8'(PRG_IDX))      new_mode = M_PRG;
        else if (bus.ioctl_index == 8'(CRT_IDX)) new_mode = M_CRT;
        else if (bus.ioctl_index == 8'(RAW_IDX)) new_mode = M_RAW;
        else                                     new_mode = M_OTHER;
    end

    // Fixup entry k = fix_idx/2; odd steps address the pointer's high byte.
    always_comb begin
        fix_addr = PTR_LIST[int'(fix_idx >> 1) * ADDR_W +: ADDR_W] + ADDR_W'(fix_idx[0]);
        fix_data = fix_idx[0] ? end_addr[15:8] : end_addr[7:0];
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        hdr_lo_ld = 1'b0;
        hdr_hi_ld = 1'b0;
        byte_ok   = 1'b0;
        byte_drop = 1'b0;
        fix_go    = 1'b0;
        limit     = (mode == M_PRG) ? PRG_LIMIT : CART_LIMIT;

        case (state)
            S_HDR_LO: begin
                if (fall) begin
                    state_nxt = S_DONE;
                end else if (bus.ioctl_wr && bus.ioctl_addr == 25'd0) begin
                    hdr_lo_ld = 1'b1;
                    state_nxt = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (fall) begin
                    state_nxt = S_DONE;
                end else if (bus.ioctl_wr && bus.ioctl_addr == 25'd1) begin
                    hdr_hi_ld = 1'b1;
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (bus.ioctl_wr) begin
                    if (addr < limit) byte_ok   = 1'b1;
                    else              byte_drop = 1'b1;
                end
                if (fall) state_nxt = (mode == M_PRG) ? S_FIX : S_DONE;
            end
            S_FIX: begin
                if (gap_cnt == '0) begin
                    fix_go = 1'b1;
                    if (fix_idx == FIX_W'(NFIX - 1)) state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: ;
        endcase

        // A new download (including one that cuts a fixup short) restarts
        // parsing and suppresses anything the old state would have done.
        if (rise_go) begin
            state_nxt = (new_mode == M_RAW) ? S_STREAM : S_HDR_LO;
            hdr_lo_ld = 1'b0;
            hdr_hi_ld = 1'b0;
            byte_ok   = 1'b0;
            byte_drop = 1'b0;
            fix_go    = 1'b0;
        end
    end

    assign addr_nxt = byte_ok ? addr + 1'b1 : addr;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // Keep tracking the level during reset: a reset in the middle of
            // a download must not look like a fresh rising edge afterwards.
            dl_q        <= bus.ioctl_download;
            mode        <= M_OTHER;
            addr        <= '0;
            end_addr    <= '0;
            bus.dl_addr <= '0;
            bus.dl_data <= '0;
            bus.dl_wr   <= 1'b0;
            cart_blk    <= '0;
            cart_reset  <= 1'b0;
            overflow    <= 1'b0;
            fix_idx     <= '0;
            gap_cnt     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            dl_q      <= bus.ioctl_download;
            bus.dl_wr <= 1'b0;

            if (fall) cart_reset <= 1'b0;

            if (hdr_lo_ld) addr[7:0]  <= bus.ioctl_dout;
            if (hdr_hi_ld) addr[15:8] <= bus.ioctl_dout;

            if (state == S_STREAM) begin
                addr     <= addr_nxt;
                end_addr <= addr_nxt;
            end

            if (byte_ok) begin
                bus.dl_addr <= addr;
                bus.dl_data <= bus.ioctl_dout;
                bus.dl_wr   <= 1'b1;
                if (mode != M_PRG) cart_blk[addr[ADDR_W-1 -: BLK_BITS]] <= 1'b1;
            end
            if (byte_drop) overflow <= 1'b1;

            if (state == S_STREAM && fall && mode == M_PRG) begin
                fix_idx <= '0;
                gap_cnt <= '0;
            end

            if (fix_go) begin
                bus.dl_addr <= fix_addr;
                bus.dl_data <= fix_data;
                bus.dl_wr   <= 1'b1;
                fix_idx     <= fix_idx + 1'b1;
                gap_cnt     <= GAP_W'(FIX_GAP - 1);
            end else if (state == S_FIX) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (rise_go) begin
                mode <= new_mode;
                addr <= (new_mode == M_RAW) ? raw_base(bus.ioctl_file_ext[7:0]) : '0;
                if (new_mode != M_PRG) cart_reset <= 1'b1;
            end
        end
    end

endmodule
